kf_pic_priority_engine: RTL and testbench
=========================================

Name: kf_pic_priority_engine

Overview:
- Parametrised, registered successor to the 8-level combinational priority resolver. It holds the in-service register (ISR) and the rotating priority pointer, and drives a registered interrupt output with an acknowledge handshake.
- Supports N request lines, fixed or rotating priority, auto-EOI, specific and non-specific EOI, special-mask and special-fully-nested modes, and a spurious-acknowledge path.
- Sits between the IRR/edge-detect block and the control/vector logic of a wide PIC.

Parameters:
- NUM_IRQ, 8, number of request levels; legal range 2..32, not required to be a power of two.
- IDX_W, $clog2(NUM_IRQ), width of level indices.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- irq_request  in  NUM_IRQ  IRR contents, level-held by the upstream block.
- interrupt_mask  in  NUM_IRQ  IMR; 1 = level masked.
- special_mask_mode  in  1  SMM enable.
- special_fully_nest  in  1  SFNM enable.
- auto_eoi  in  1  AEOI enable.
- auto_rotate  in  1  rotate priority on AEOI/EOI.
- int_ack  in  1  single-cycle acknowledge pulse.
- eoi_nonspecific  in  1  pulse; clear the highest-priority ISR bit.
- eoi_specific  in  1  pulse; clear ISR[eoi_level].
- eoi_level  in  IDX_W  level for specific EOI.
- set_priority  in  1  pulse; make priority_level the lowest priority.
- priority_level  in  IDX_W  level used by set_priority.
- int_out  out  1  registered interrupt request to the CPU side.
- ack_idx  out  IDX_W  level granted on the last acknowledge.
- ack_spurious  out  1  last acknowledge found no winner.
- in_service  out  NUM_IRQ  ISR.
- prio_base  out  IDX_W  index of the current highest-priority level.

Behaviour:
- Reset (async, reset_n=0): int_out=0, ack_idx=0, ack_spurious=0, in_service=0, prio_base=0.
- Priority order: prio_base is highest. Priority descends through prio_base+1 … wrapping modulo NUM_IRQ, with explicit compare-and-subtract; no power-of-two wrap.
- Candidates: cand = irq_request & ~interrupt_mask.
- Blocking set B = in_service. In SMM, B = in_service & ~interrupt_mask.
- Normal mode: an ISR bit in B blocks its own level and all lower levels.
- SFNM: the highest-priority ISR bit blocks only strictly lower levels, so the same level may re-request.
- SMM: each ISR bit in B blocks only its own level.
- Winner: highest-priority level of cand that is not blocked.
- int_out: registered. Equals winner_valid one cycle after inputs settle.
- int_out is forced to 0 in the cycle after int_ack, then re-evaluates.
- int_ack with a winner:
  - ack_idx <= winner, ack_spurious <= 0.
  - If auto_eoi=0, set ISR[winner].
  - If auto_eoi=1, ISR is left unchanged; if auto_rotate=1, prio_base <= (winner+1) mod NUM_IRQ.
- int_ack with no winner: ack_spurious <= 1, ack_idx <= NUM_IRQ-1, ISR unchanged.
- eoi_nonspecific: clear the highest-priority set ISR bit. No-op if ISR=0. If auto_rotate=1 and a bit was cleared, prio_base <= cleared+1 mod N.
- eoi_specific: clear ISR[eoi_level]. If auto_rotate=1, prio_base <= eoi_level+1 mod N.
- eoi_level >= NUM_IRQ is ignored.
- set_priority: prio_base <= priority_level+1 mod N.
- Simultaneous events in one cycle:
  - ISR_next = (ISR & ~eoi_clear) | ack_set.
  - EOI and ack are evaluated against the current-cycle ISR and prio_base.
  - prio_base source precedence: set_priority > EOI rotate > AEOI rotate.
  - eoi_specific and eoi_nonspecific together: specific wins.
- Mask or request changes while int_out=1 may drop or redirect the winner. int_ack always uses the winner of the ack cycle.

Decomposition:
- Shared package kf_pic_pkg:
  - functions rotate_right_n and rotate_left_n, parametrised by width and modulo amount;
  - function find_first_set;
  - localparam for the spurious index.
- One sub-module, kf_pic_ffs: combinational find-first-set starting from a base index, returning valid plus index. It is instantiated twice: once for the winner, once for the highest ISR.

Test Plan:
- Reset, then irq_request=8'h28, mask=0 → int_out=1 next cycle; int_ack → ack_idx=3, in_service=8'h08.
- ISR=8'h08 (normal mode), irq_request=8'h21 → bit 0 wins. With ISR=8'h01, request 8'h20 is blocked and int_out=0. With SMM=1 and mask=8'h01, request 8'h20 is granted.
- NUM_IRQ=12, auto_eoi=1, auto_rotate=1, request bit 11, int_ack → prio_base wraps to 0; ISR stays 0.
- set_priority with priority_level=4 → prio_base=5. Requests 8'h11 → level 0 is granted after 4 wins? No: level 4 is lowest priority, so level 0 wins.
- int_ack with a masked-only request → ack_spurious=1, ack_idx=NUM_IRQ-1, ISR unchanged.
- Same cycle: int_ack (winner 2) and eoi_specific level 5 with ISR=8'h20 → ISR=8'h04. Assert reset_n mid-sequence → all outputs return to zero asynchronously.

Source files
------------

// File: rtl/kf_pic_pkg.sv
// Shared helpers for the wide PIC priority engine: rotation of request
// vectors around a moving priority base, a find-first-set scan and the
// constants both the engine and its find-first-set sub-block rely on.
package kf_pic_pkg;

  // Widest request vector the helper functions handle.
  localparam int unsigned KF_MAX_IRQ = 32;

  // A spurious acknowledge reports the level this far below NUM_IRQ,
  // i.e. the last (numerically highest) level index.
  localparam int unsigned KF_SPURIOUS_FROM_TOP = 1;

  // How in-service bits suppress other levels.
  typedef enum logic [1:0] {
    NEST_NORMAL = 2'd0,
    NEST_SFNM   = 2'd1,
    NEST_SMM    = 2'd2
  } nest_mode_e;

  // Bit i of the result is bit (i + amt) mod n of v, so the level at the
  // priority base lands at position 0. Bits at or above n come back as zero.
  // The modulo is a compare-and-subtract, so n need not be a power of two.
  function automatic logic [KF_MAX_IRQ-1:0] rotate_right_n(
    input logic [KF_MAX_IRQ-1:0] v,
    input int unsigned           amt,
    input int unsigned           n
  );
    logic [KF_MAX_IRQ-1:0] r;
    int unsigned           src;
    r   = '0;
    src = 0;
    for (int unsigned i = 0; i < KF_MAX_IRQ; i++) begin
      if (i < n) begin
        src = i + amt;
        if (src >= n) src = src - n;
        r[i[4:0]] = v[src[4:0]];
      end
    end
    return r;
  endfunction

  // Inverse of rotate_right_n: bit i of the result is bit (i - amt) mod n of v.
  function automatic logic [KF_MAX_IRQ-1:0] rotate_left_n(
    input logic [KF_MAX_IRQ-1:0] v,
    input int unsigned           amt,
    input int unsigned           n
  );
    logic [KF_MAX_IRQ-1:0] r;
    int unsigned           src;
    r   = '0;
    src = 0;
    for (int unsigned i = 0; i < KF_MAX_IRQ; i++) begin
      if (i < n) begin
        if (i >= amt) src = i - amt;
        else          src = i + n - amt;
        r[i[4:0]] = v[src[4:0]];
      end
    end
    return r;
  endfunction

  // Position of the lowest set bit, or -1 when v is all zeros.
  function automatic int find_first_set(input logic [KF_MAX_IRQ-1:0] v);
    int r;
    r = -1;
    for (int i = KF_MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i[4:0]]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/kf_pic_ffs.sv
// Combinational find-first-set that starts its search at a base index and
// wraps modulo NUM_IRQ. Used by the engine both to pick the winning request
// and to locate the highest-priority in-service level.
import kf_pic_pkg::*;

module kf_pic_ffs #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_vec,
  input  logic [IDX_W-1:0]   i_base,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  logic [KF_MAX_IRQ-1:0] w_rot;
  int                    w_pos;
  int                    w_lvl;

  // Rotate so the base is position 0, scan, then map the position back to a level.
  always_comb begin
    w_rot   = rotate_right_n(KF_MAX_IRQ'(i_vec), int'(i_base), NUM_IRQ);
    w_pos   = find_first_set(w_rot);
    w_lvl   = w_pos + int'(i_base);
    if (w_lvl >= NUM_IRQ) w_lvl = w_lvl - NUM_IRQ;
    o_valid = (w_pos >= 0);
    o_idx   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (w_lvl == k) o_idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/kf_pic_priority_engine.sv
// Registered priority engine for a wide PIC. Holds the in-service register
// and the rotating priority base, resolves the winning request under
// normal, special-fully-nested or special-mask nesting, and services the
// acknowledge, EOI and set-priority pulses.
import kf_pic_pkg::*;

module kf_pic_priority_engine #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_request,
  input  logic [NUM_IRQ-1:0] interrupt_mask,
  input  logic               special_mask_mode,
  input  logic               special_fully_nest,
  input  logic               auto_eoi,
  input  logic               auto_rotate,
  input  logic               int_ack,
  input  logic               eoi_nonspecific,
  input  logic               eoi_specific,
  input  logic [IDX_W-1:0]   eoi_level,
  input  logic               set_priority,
  input  logic [IDX_W-1:0]   priority_level,
  output logic               int_out,
  output logic [IDX_W-1:0]   ack_idx,
  output logic               ack_spurious,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [IDX_W-1:0]   prio_base
);

  localparam logic [IDX_W-1:0] SPURIOUS_IDX = IDX_W'(NUM_IRQ - KF_SPURIOUS_FROM_TOP);

  logic               r_int_out;
  logic [IDX_W-1:0]   r_ack_idx;
  logic               r_ack_spurious;
  logic [NUM_IRQ-1:0] r_isr;
  logic [IDX_W-1:0]   r_prio_base;

  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_block_src;
  logic [NUM_IRQ-1:0] w_blocked;
  logic [NUM_IRQ-1:0] w_elig;
  nest_mode_e         w_mode;
  int                 w_rel [NUM_IRQ];

  logic               w_win_valid;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_isr_valid;
  logic [IDX_W-1:0]   w_isr_idx;

  logic               w_ack_hit;
  logic [NUM_IRQ-1:0] w_ack_set;
  logic [NUM_IRQ-1:0] w_eoi_clear;
  logic               w_eoi_done;
  logic [IDX_W-1:0]   w_eoi_lvl;
  logic [NUM_IRQ-1:0] w_isr_next;
  logic [IDX_W-1:0]   w_base_next;

  // Next level after v in index order, wrapping at NUM_IRQ without relying on a power-of-two size.
  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
    if (int'(v) >= NUM_IRQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // Candidates, blocking source and the active nesting mode; SMM dominates SFNM.
  always_comb begin
    w_cand      = irq_request & ~interrupt_mask;
    w_block_src = special_mask_mode ? (r_isr & ~interrupt_mask) : r_isr;
    if (special_mask_mode)       w_mode = NEST_SMM;
    else if (special_fully_nest) w_mode = NEST_SFNM;
    else                         w_mode = NEST_NORMAL;
  end

  // Rank of each level below the base (0 = highest priority), by compare-and-subtract.
  always_comb begin
    for (int l = 0; l < NUM_IRQ; l++) begin
      if (l >= int'(r_prio_base)) w_rel[l] = l - int'(r_prio_base);
      else                        w_rel[l] = l + NUM_IRQ - int'(r_prio_base);
    end
  end

  // A level is blocked by any in-service level that outranks it under the current nesting mode.
  always_comb begin
    w_blocked = '0;
    for (int l = 0; l < NUM_IRQ; l++) begin
      for (int m = 0; m < NUM_IRQ; m++) begin
        if (w_block_src[m]) begin
          case (w_mode)
            NEST_SMM:  if (m == l)              w_blocked[l] = 1'b1;
            NEST_SFNM: if (w_rel[m] < w_rel[l])  w_blocked[l] = 1'b1;
            default:   if (w_rel[m] <= w_rel[l]) w_blocked[l] = 1'b1;
          endcase
        end
      end
    end
    w_elig = w_cand & ~w_blocked;
  end

  kf_pic_ffs #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_win_ffs (
    .i_vec   (w_elig),
    .i_base  (r_prio_base),
    .o_valid (w_win_valid),
    .o_idx   (w_win_idx)
  );

  kf_pic_ffs #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_isr_ffs (
    .i_vec   (r_isr),
    .i_base  (r_prio_base),
    .o_valid (w_isr_valid),
    .o_idx   (w_isr_idx)
  );

  // EOI clear selection: a specific EOI suppresses a simultaneous non-specific one; out-of-range levels do nothing.
  always_comb begin
    w_eoi_clear = '0;
    w_eoi_done  = 1'b0;
    w_eoi_lvl   = '0;
    if (eoi_specific) begin
      if (int'(eoi_level) < NUM_IRQ) begin
        w_eoi_clear[eoi_level] = 1'b1;
        w_eoi_done             = 1'b1;
        w_eoi_lvl              = eoi_level;
      end
    end else if (eoi_nonspecific && w_isr_valid) begin
      w_eoi_clear[w_isr_idx] = 1'b1;
      w_eoi_done             = 1'b1;
      w_eoi_lvl              = w_isr_idx;
    end
  end

  // ISR update and priority-base source; set_priority beats EOI rotation, which beats AEOI rotation.
  always_comb begin
    w_ack_hit = int_ack && w_win_valid;
    w_ack_set = '0;
    if (w_ack_hit && !auto_eoi) w_ack_set[w_win_idx] = 1'b1;
    w_isr_next = (r_isr & ~w_eoi_clear) | w_ack_set;

    w_base_next = r_prio_base;
    if (set_priority && (int'(priority_level) < NUM_IRQ)) begin
      w_base_next = inc_mod(priority_level);
    end else if (w_eoi_done && auto_rotate) begin
      w_base_next = inc_mod(w_eoi_lvl);
    end else if (w_ack_hit && auto_eoi && auto_rotate) begin
      w_base_next = inc_mod(w_win_idx);
    end
  end

  // Interrupt output follows the winner but drops for one cycle after each acknowledge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_int_out <= 1'b0;
    else          r_int_out <= int_ack ? 1'b0 : w_win_valid;
  end

  // Capture the granted level, or flag a spurious acknowledge when nothing was eligible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_idx      <= '0;
      r_ack_spurious <= 1'b0;
    end else if (int_ack) begin
      if (w_win_valid) begin
        r_ack_idx      <= w_win_idx;
        r_ack_spurious <= 1'b0;
      end else begin
        r_ack_idx      <= SPURIOUS_IDX;
        r_ack_spurious <= 1'b1;
      end
    end
  end

  // In-service register and rotating priority base.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_isr       <= '0;
      r_prio_base <= '0;
    end else begin
      r_isr       <= w_isr_next;
      r_prio_base <= w_base_next;
    end
  end

  assign int_out      = r_int_out;
  assign ack_idx      = r_ack_idx;
  assign ack_spurious = r_ack_spurious;
  assign in_service   = r_isr;
  assign prio_base    = r_prio_base;

endmodule

// File: tb/tb_kf_pic_priority_engine.sv
// Bench for the PIC priority engine: an 8-level instance carries most of the
// directed vectors, a 12-level instance with AEOI and auto-rotate exercises
// the non-power-of-two wrap. Expectations are queued by the stimulus and
// popped by a monitor on the falling edge.
module tb_kf_pic_priority_engine;

  typedef struct {
    int    dut;
    logic  intOut;
    int    ackIdx;
    logic  spurious;
    int    isr;
    int    base;
    string name;
  } exp_t;

  exp_t scoreboard[$];
  int   checksDone  = 0;
  int   checksPassed = 0;

  logic       clock = 1'b0;
  logic       reset_n;

  logic [7:0] aReq, aMask;
  logic       aSmm, aSfnm, aAeoi, aArot, aAck, aEoiN, aEoiS, aSetP;
  logic [2:0] aEoiLvl, aPrioLvl;
  logic       aIntOut, aSpur;
  logic [2:0] aAckIdx, aBase;
  logic [7:0] aIsr;

  logic [11:0] bReq;
  logic        bAck;
  logic        bIntOut, bSpur;
  logic [3:0]  bAckIdx, bBase;
  logic [11:0] bIsr;

  always #5 clock = ~clock;

  kf_pic_priority_engine #(.NUM_IRQ(8)) dut8 (
    .clock              (clock),
    .reset_n            (reset_n),
    .irq_request        (aReq),
    .interrupt_mask     (aMask),
    .special_mask_mode  (aSmm),
    .special_fully_nest (aSfnm),
    .auto_eoi           (aAeoi),
    .auto_rotate        (aArot),
    .int_ack            (aAck),
    .eoi_nonspecific    (aEoiN),
    .eoi_specific       (aEoiS),
    .eoi_level          (aEoiLvl),
    .set_priority       (aSetP),
    .priority_level     (aPrioLvl),
    .int_out            (aIntOut),
    .ack_idx            (aAckIdx),
    .ack_spurious       (aSpur),
    .in_service         (aIsr),
    .prio_base          (aBase)
  );

  kf_pic_priority_engine #(.NUM_IRQ(12)) dut12 (
    .clock              (clock),
    .reset_n            (reset_n),
    .irq_request        (bReq),
    .interrupt_mask     (12'h000),
    .special_mask_mode  (1'b0),
    .special_fully_nest (1'b0),
    .auto_eoi           (1'b1),
    .auto_rotate        (1'b1),
    .int_ack            (bAck),
    .eoi_nonspecific    (1'b0),
    .eoi_specific       (1'b0),
    .eoi_level          (4'd0),
    .set_priority       (1'b0),
    .priority_level     (4'd0),
    .int_out            (bIntOut),
    .ack_idx            (bAckIdx),
    .ack_spurious       (bSpur),
    .in_service         (bIsr),
    .prio_base          (bBase)
  );

  // Advance one clock so the inputs driven beforehand are captured.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  // Queue the outputs a DUT must show at the next falling edge.
  task automatic checkOutput(input int dut, input logic io, input int ack, input logic sp,
                             input int isr, input int base, input string name);
    exp_t e;
    e.dut = dut; e.intOut = io; e.ackIdx = ack; e.spurious = sp;
    e.isr = isr; e.base = base; e.name = name;
    scoreboard.push_back(e);
  endtask

  // Monitor: pop every queued expectation on the falling edge and compare.
  initial begin
    exp_t e;
    logic gIo, gSp;
    int   gAck, gIsr, gBase;
    forever begin
      @(negedge clock);
      while (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        if (e.dut == 8) begin
          gIo = aIntOut; gSp = aSpur; gAck = int'(aAckIdx); gIsr = int'(aIsr); gBase = int'(aBase);
        end else begin
          gIo = bIntOut; gSp = bSpur; gAck = int'(bAckIdx); gIsr = int'(bIsr); gBase = int'(bBase);
        end
        checksDone++;
        if (gIo === e.intOut && gSp === e.spurious && gAck == e.ackIdx &&
            gIsr == e.isr && gBase == e.base) begin
          checksPassed++;
        end else begin
          $display("[TB] FAIL %s: got int_out=%0b ack_idx=%0d spurious=%0b isr=%0h base=%0d, expected int_out=%0b ack_idx=%0d spurious=%0b isr=%0h base=%0d",
                   e.name, gIo, gAck, gSp, gIsr, gBase, e.intOut, e.ackIdx, e.spurious, e.isr, e.base);
        end
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    reset_n = 1'b0;
    aReq = '0; aMask = '0; aSmm = 0; aSfnm = 0; aAeoi = 0; aArot = 0;
    aAck = 0; aEoiN = 0; aEoiS = 0; aEoiLvl = '0; aSetP = 0; aPrioLvl = '0;
    bReq = '0; bAck = 0;
    applyStimulus();
    applyStimulus();
    checkOutput(8,  0, 0, 0, 0, 0, "reset8");
    checkOutput(12, 0, 0, 0, 0, 0, "reset12");
    reset_n = 1'b1;
    applyStimulus();

    // 12-level: AEOI with rotate, including the wrap from level 11 to 0
    bReq = 12'h020; applyStimulus();
    checkOutput(12, 1, 0, 0, 0, 0, "d12_req5");
    bAck = 1; applyStimulus(); bAck = 0;
    checkOutput(12, 0, 5, 0, 0, 6, "d12_ack5_rotate");
    bReq = 12'h800; applyStimulus();
    checkOutput(12, 1, 5, 0, 0, 6, "d12_req11");
    bAck = 1; applyStimulus(); bAck = 0; bReq = '0;
    checkOutput(12, 0, 11, 0, 0, 0, "d12_wrap");

    // 8-level: basic grant and nesting
    aReq = 8'h28; applyStimulus();
    checkOutput(8, 1, 0, 0, 8'h00, 0, "first_req");
    aAck = 1; applyStimulus(); aAck = 0;
    checkOutput(8, 0, 3, 0, 8'h08, 0, "ack_lvl3");
    aReq = 8'h21; applyStimulus();
    checkOutput(8, 1, 3, 0, 8'h08, 0, "nest_lvl0");
    aAck = 1; applyStimulus(); aAck = 0;
    checkOutput(8, 0, 0, 0, 8'h09, 0, "ack_lvl0");
    aEoiS = 1; aEoiLvl = 3'd3; aReq = 8'h20; applyStimulus(); aEoiS = 0;
    checkOutput(8, 0, 0, 0, 8'h01, 0, "eoi_spec3");
    applyStimulus();
    checkOutput(8, 0, 0, 0, 8'h01, 0, "blocked_lvl5");

    // special mask mode lets a lower level through
    aSmm = 1; aMask = 8'h01; applyStimulus();
    checkOutput(8, 1, 0, 0, 8'h01, 0, "smm_grant5");
    aAck = 1; applyStimulus(); aAck = 0;
    checkOutput(8, 0, 5, 0, 8'h21, 0, "smm_ack5");
    aSmm = 0; aMask = '0; aReq = '0; aEoiN = 1; applyStimulus(); aEoiN = 0;
    checkOutput(8, 0, 5, 0, 8'h20, 0, "eoi_nonspec");

    // ack and specific EOI in the same cycle
    aReq = 8'h04; applyStimulus();
    checkOutput(8, 1, 5, 0, 8'h20, 0, "req_lvl2");
    aAck = 1; aEoiS = 1; aEoiLvl = 3'd5; applyStimulus();
    aAck = 0; aEoiS = 0; aReq = '0;
    checkOutput(8, 0, 2, 0, 8'h04, 0, "ack_eoi_same");

    // rotation and set_priority
    aEoiS = 1; aEoiLvl = 3'd2; aArot = 1; applyStimulus(); aEoiS = 0; aArot = 0;
    checkOutput(8, 0, 2, 0, 8'h00, 3, "eoi_rotate");
    aSetP = 1; aPrioLvl = 3'd4; applyStimulus(); aSetP = 0;
    checkOutput(8, 0, 2, 0, 8'h00, 5, "set_prio4");
    aReq = 8'h11; applyStimulus();
    checkOutput(8, 1, 2, 0, 8'h00, 5, "rot_req");
    aAck = 1; applyStimulus(); aAck = 0;
    checkOutput(8, 0, 0, 0, 8'h01, 5, "rot_win0");
    aEoiN = 1; aArot = 1; aSetP = 1; aPrioLvl = 3'd1; aReq = '0; applyStimulus();
    aEoiN = 0; aArot = 0; aSetP = 0;
    checkOutput(8, 0, 0, 0, 8'h00, 2, "prio_precedence");

    // spurious acknowledge
    aReq = 8'h40; aMask = 8'h40; aAck = 1; applyStimulus();
    aAck = 0; aReq = '0; aMask = '0;
    checkOutput(8, 0, 7, 1, 8'h00, 2, "spurious");

    // special fully nested re-request of the in-service level
    aReq = 8'h08; applyStimulus();
    checkOutput(8, 1, 7, 1, 8'h00, 2, "req_lvl3");
    aAck = 1; applyStimulus(); aAck = 0;
    checkOutput(8, 0, 3, 0, 8'h08, 2, "ack_lvl3b");
    aSfnm = 1; applyStimulus();
    checkOutput(8, 1, 3, 0, 8'h08, 2, "sfnm_rereq");
    aSfnm = 0; applyStimulus();
    checkOutput(8, 0, 3, 0, 8'h08, 2, "normal_block_same");

    // asynchronous reset between clock edges
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(8,  0, 0, 0, 0, 0, "async_reset8");
    checkOutput(12, 0, 0, 0, 0, 0, "async_reset12");

    @(negedge clock);
    #1;
    @(negedge clock);
    #1;
    if (scoreboard.size() != 0) begin
      checksDone++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", scoreboard.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
